regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass.sv | 108 ++++++++++
 tb/tb_regfile_bypass.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
//   8 x 16-bit register file. It has two combinational read ports with
//   same-cycle write-back bypass, and one write-back port. A one-bit-per-
//   register busy scoreboard tracks registers whose producer has issued but
//   not yet written back. The scoreboard drives the decode Stall signal.
//
// Ports
//   clk                 system clock, all state updates on the rising edge
//   rst                 asynchronous active-high reset
//   ReadReg1/ReadReg2   source register indices, read ports 1/2
//   Rd1Used/Rd2Used     operand on port 1/2 is consumed by the issuing instr
//   ReadData1/ReadData2 read data, bypassed from WriteData on index match
//   WriteEn             write-back valid
//   WriteReg            write-back destination index
//   WriteData           write-back data
//   IssueEn             decode requests issue of an instr writing IssueReg
//   IssueReg            destination index of the issuing instruction
//   Stall               issue blocked: a used source is pending, not bypassable
//   Err                 sticky: write-back hit a register with no producer
// ---------------------------------------------------------------------------
module regfile_bypass (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ReadReg1,
  input  logic [2:0]  ReadReg2,
  input  logic        Rd1Used,
  input  logic        Rd2Used,
  output logic [15:0] ReadData1,
  output logic [15:0] ReadData2,
  input  logic        WriteEn,
  input  logic [2:0]  WriteReg,
  input  logic [15:0] WriteData,
  input  logic        IssueEn,
  input  logic [2:0]  IssueReg,
  output logic        Stall,
  output logic        Err
);

  logic [15:0] regs [8];
  logic [7:0]  busy;
  logic [7:0]  busyNext;
  logic        errSticky;

  logic        bypass1;
  logic        bypass2;
  logic        issueAccept;

  // A write-back to the register being read is forwarded in the same cycle.
  // It also resolves that register's pending hazard.
  assign bypass1 = WriteEn && (WriteReg == ReadReg1);
  assign bypass2 = WriteEn && (WriteReg == ReadReg2);

  assign ReadData1 = bypass1 ? WriteData : regs[ReadReg1];
  assign ReadData2 = bypass2 ? WriteData : regs[ReadReg2];

  assign Stall = (Rd1Used && busy[ReadReg1] && !bypass1) ||
                 (Rd2Used && busy[ReadReg2] && !bypass2);

  assign issueAccept = IssueEn && !Stall;

  // Scoreboard update. The issue is applied after the clear, so a new
  // producer issued on the same edge as the old one's write-back keeps the
  // register busy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    busyNext = busy;
    if (WriteEn) begin
      busyNext[WriteReg] = 1'b0;
    end
    if (issueAccept) begin
      busyNext[IssueReg] = 1'b1;
    end
  end

  // NOTE: the register array is inside the reset on purpose. The design
  // must read back zeros immediately after reset, so this storage cannot be
  // left as uninitialised RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (WriteEn) begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // then samples pre-edge values, regardless of block ordering.
      regs[WriteReg] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 8'h00;
      errSticky <= 1'b0;
    end else begin
      busy <= busyNext;
      // The data write above still happens. The error only records that
      // nothing was waiting for this result.
      if (WriteEn && !busy[WriteReg]) begin
        errSticky <= 1'b1;
      end
    end
  end

  assign Err = errSticky;

endmodule

// File: tb/tb_regfile_bypass.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass
//   Directed bench for regfile_bypass. A table of per-cycle vectors is
//   applied in order, so scoreboard state carries from row to row. Each row
//   checks the combinational outputs and the registered Err before the edge
//   that commits the row. Hand-written sequences follow for the remaining
//   cases: asynchronous mid-cycle reset, behaviour while reset is held, and
//   the first write-back after reset.
// ---------------------------------------------------------------------------
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ReadReg1, ReadReg2;
  logic        Rd1Used, Rd2Used;
  logic [15:0] ReadData1, ReadData2;
  logic        WriteEn;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic        IssueEn;
  logic [2:0]  IssueReg;
  logic        Stall, Err;

  int checks = 0;
  int errors = 0;

  regfile_bypass dut (
    .clk(clk), .rst(rst),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .Rd1Used(Rd1Used), .Rd2Used(Rd2Used),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteEn(WriteEn), .WriteReg(WriteReg), .WriteData(WriteData),
    .IssueEn(IssueEn), .IssueReg(IssueReg),
    .Stall(Stall), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rr1;
    logic        u1;
    logic [2:0]  rr2;
    logic        u2;
    logic        we;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        ie;
    logic [2:0]  ir;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eStall;
    logic        eErr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [2:0] rr1, input logic u1, input logic [2:0] rr2, input logic u2,
    input logic we, input logic [2:0] wr, input logic [15:0] wd,
    input logic ie, input logic [2:0] ir,
    input logic [15:0] e1, input logic [15:0] e2, input logic es, input logic ee);
    vec_t v;
    v.rr1 = rr1; v.u1 = u1; v.rr2 = rr2; v.u2 = u2;
    v.we = we; v.wr = wr; v.wd = wd; v.ie = ie; v.ir = ir;
    v.e1 = e1; v.e2 = e2; v.eStall = es; v.eErr = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] rr1, input logic u1, input logic [2:0] rr2,
                       input logic u2, input logic we, input logic [2:0] wr,
                       input logic [15:0] wd, input logic ie, input logic [2:0] ir);
    ReadReg1 = rr1; Rd1Used = u1; ReadReg2 = rr2; Rd2Used = u2;
    WriteEn = we; WriteReg = wr; WriteData = wd; IssueEn = ie; IssueReg = ir;
  endtask

  task automatic checkAll(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                          input logic es, input logic ee);
    check({tag, " ReadData1"}, ReadData1, e1);
    check({tag, " ReadData2"}, ReadData2, e2);
    check({tag, " Stall"}, {15'd0, Stall}, {15'd0, es});
    check({tag, " Err"}, {15'd0, Err}, {15'd0, ee});
  endtask

  initial begin
    // Expected values follow the state carried from row to row.
    //            rr1 u1 rr2 u2 we wr wd        ie ir  e1        e2        st er
    vecs[0]  = mk(3, 0, 3, 0, 0, 0, 16'h0000, 1, 3, 16'h0000, 16'h0000, 0, 0); // issue R3
    vecs[1]  = mk(3, 1, 3, 1, 1, 3, 16'hBEEF, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0); // wb R3, bypass both
    vecs[2]  = mk(3, 1, 3, 1, 0, 0, 16'h0000, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0); // stored R3
    vecs[3]  = mk(3, 0, 0, 0, 0, 0, 16'h0000, 1, 5, 16'hBEEF, 16'h0000, 0, 0); // issue R5
    vecs[4]  = mk(5, 1, 3, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'hBEEF, 1, 0); // RAW stall, R1 rejected
    vecs[5]  = mk(5, 1, 1, 1, 1, 5, 16'h1234, 0, 0, 16'h1234, 16'h0000, 0, 0); // wb R5 resolves, R1 free
    vecs[6]  = mk(5, 1, 2, 0, 0, 0, 16'h0000, 1, 2, 16'h1234, 16'h0000, 0, 0); // issue R2
    vecs[7]  = mk(2, 1, 5, 1, 1, 2, 16'h00FF, 1, 2, 16'h00FF, 16'h1234, 0, 0); // issue+wb R2 same edge
    vecs[8]  = mk(2, 1, 2, 0, 0, 0, 16'h0000, 0, 0, 16'h00FF, 16'h00FF, 1, 0); // R2 still busy
    vecs[9]  = mk(2, 1, 0, 0, 1, 2, 16'h0102, 0, 0, 16'h0102, 16'h0000, 0, 0); // second wb R2
    vecs[10] = mk(7, 1, 2, 1, 1, 7, 16'h5A5A, 0, 0, 16'h5A5A, 16'h0102, 0, 0); // wb R7 unissued
    vecs[11] = mk(7, 1, 2, 1, 0, 0, 16'h0000, 0, 0, 16'h5A5A, 16'h0102, 0, 1); // Err now set
    vecs[12] = mk(7, 0, 3, 0, 0, 0, 16'h0000, 1, 4, 16'h5A5A, 16'hBEEF, 0, 1); // issue R4, Err holds
    vecs[13] = mk(0, 1, 4, 0, 0, 0, 16'h0000, 1, 6, 16'h0000, 16'h0000, 0, 1); // Rd2Used masks busy R4
    vecs[14] = mk(6, 1, 4, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1); // R6 and R4 busy

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    repeat (2) @(negedge clk);
    #1 checkAll("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rr1, vecs[i].u1, vecs[i].rr2, vecs[i].u2, vecs[i].we,
            vecs[i].wr, vecs[i].wd, vecs[i].ie, vecs[i].ir);
      #1 checkAll($sformatf("row%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].eStall, vecs[i].eErr);
    end

    // Asynchronous reset asserted away from any clock edge.
    @(negedge clk);
    drive(6, 1, 4, 1, 0, 0, 16'h0000, 0, 0);
    #1 check("pre-rst Stall", {15'd0, Stall}, 16'd1);
    rst = 1'b1;
    #1 check("async-rst Stall", {15'd0, Stall}, 16'd0);
    check("async-rst Err", {15'd0, Err}, 16'd0);
    drive(3, 1, 7, 1, 0, 0, 16'h0000, 0, 0);
    #1 check("async-rst R3", ReadData1, 16'h0000);
    check("async-rst R7", ReadData2, 16'h0000);

    // While reset is held, bypass remains visible but nothing is recorded.
    @(negedge clk);
    drive(1, 1, 5, 0, 1, 1, 16'hAAAA, 1, 2);
    #1 check("rst-held bypass", ReadData1, 16'hAAAA);
    check("rst-held R5", ReadData2, 16'h0000);
    @(negedge clk);
    drive(1, 0, 2, 1, 0, 0, 16'h0000, 0, 0);
    #1 check("rst-held R1 not written", ReadData1, 16'h0000);
    check("rst-held no issue", {15'd0, Stall}, 16'd0);
    rst = 1'b0;

    // R0 is an ordinary register: issue it, write it back, and read it.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 1, 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 1, 0, 16'h0C0C, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, 1, 0, 0, 16'h0000, 0, 0);
    #1 checkAll("R0", 16'h0C0C, 16'h0000, 1'b0, 1'b0);

    // R4 was pending before the reset. That producer is gone, so this
    // write-back is unexpected and must set Err.
    @(negedge clk);
    drive(4, 1, 0, 0, 1, 4, 16'h1111, 0, 0);
    #1 check("post-rst wb Stall", {15'd0, Stall}, 16'd0);
    @(negedge clk);
    drive(4, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
    #1 checkAll("post-rst Err", 16'h1111, 16'h0C0C, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
